// File: rtl/lucky_seven_scrambler.sv
// Legal-move generator for the eight-cell Lucky Seven board (ring 0..7 plus chord 0-4).
// Tracks the empty cell and issues LFSR-chosen moves over a valid/ready handshake.
module lucky_seven_scrambler #(
  parameter logic [7:0] SEED   = 8'h01,
  parameter bit         NOUNDO = 1'b1,
  parameter int         CNT_W  = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] nmoves,
  input  logic [2:0]       empty_init,
  output logic             move_valid,
  input  logic             move_ready,
  output logic [2:0]       from,
  output logic [2:0]       to,
  output logic             busy,
  output logic             done,
  output logic [2:0]       empty_pos,
  output logic [CNT_W-1:0] moves_left
);

  localparam logic [7:0]       SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [2:0]       empty_q, empty_d;
  logic [2:0]       prev_q, prev_d;
  logic             prev_valid_q, prev_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [2:0]       from_q, from_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept_s;
  logic [7:0]       lfsr_nx_s;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
  endfunction

  // Candidates in order e+1, e-1, e^4 (cells 0/4 only), minus the undo cell,
  // then indexed by the low LFSR bits.
  function automatic logic [2:0] pick_from(input logic [2:0] e,
                                           input logic [2:0] prev,
                                           input logic       pv,
                                           input logic [2:0] rnd);
    logic       filt;
    logic [2:0] c0, c1, c2;
    logic       k0, k1, k2;
    logic [2:0] l0, l1;
    logic [1:0] n;
    logic [1:0] idx;
    filt = NOUNDO && pv;
    c0   = e + 3'd1;
    c1   = e - 3'd1;
    c2   = e ^ 3'd4;
    k0   = !(filt && (c0 == prev));
    k1   = !(filt && (c1 == prev));
    k2   = (e[1:0] == 2'b00) && !(filt && (c2 == prev));
    l0   = k0 ? c0 : (k1 ? c1 : c2);
    l1   = (k0 && k1) ? c1 : c2;
    n    = {1'b0, k0} + {1'b0, k1} + {1'b0, k2};
    case (n)
      2'd1:    idx = 2'd0;
      2'd2:    idx = {1'b0, rnd[0]};
      2'd3:    idx = (rnd[1:0] == 2'b11) ? {1'b0, rnd[2]} : rnd[1:0];
      default: idx = 2'd0;
    endcase
    case (idx)
      2'd0:    return l0;
      2'd1:    return l1;
      default: return c2;
    endcase
  endfunction

  assign accept_s  = valid_q & move_ready;
  assign lfsr_nx_s = lfsr_step(lfsr_q);

  // Next-state logic; the next move is precomputed so from/to leave straight from flops.
  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    empty_d      = empty_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    from_d       = from_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (nmoves != CNT_ZERO) begin
            state_d      = S_RUN;
            empty_d      = empty_init;
            cnt_d        = nmoves;
            prev_valid_d = 1'b0;
            valid_d      = 1'b1;
            busy_d       = 1'b1;
            from_d       = pick_from(empty_init, prev_q, 1'b0, lfsr_q[2:0]);
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (accept_s) begin
          prev_d       = empty_q;
          prev_valid_d = 1'b1;
          empty_d      = from_q;
          lfsr_d       = lfsr_nx_s;
          cnt_d        = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            from_d  = 3'd0;
          end else begin
            state_d = S_RUN;
            from_d  = pick_from(from_q, empty_q, 1'b1, lfsr_nx_s[2:0]);
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any sequence without a done pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      lfsr_q       <= SEED_EFF;
      empty_q      <= 3'd0;
      prev_q       <= 3'd0;
      prev_valid_q <= 1'b0;
      cnt_q        <= CNT_ZERO;
      valid_q      <= 1'b0;
      from_q       <= 3'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      empty_q      <= empty_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      from_q       <= from_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign move_valid = valid_q;
  assign from       = from_q;
  assign to         = empty_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign empty_pos  = empty_q;
  assign moves_left = cnt_q;

endmodule

// File: tb/tb_lucky_seven_scrambler.sv
// Directed and soak bench for lucky_seven_scrambler (SEED=1, NOUNDO=1, CNT_W=8).
module tb_lucky_seven_scrambler;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic [7:0] nmoves;
  logic [2:0] empty_init;
  logic       move_valid;
  logic       move_ready;
  logic [2:0] from;
  logic [2:0] to;
  logic       busy;
  logic       done;
  logic [2:0] empty_pos;
  logic [7:0] moves_left;

  int checks = 0;
  int errors = 0;

  lucky_seven_scrambler dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .nmoves     (nmoves),
    .empty_init (empty_init),
    .move_valid (move_valid),
    .move_ready (move_ready),
    .from       (from),
    .to         (to),
    .busy       (busy),
    .done       (done),
    .empty_pos  (empty_pos),
    .moves_left (moves_left)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_valid"}, move_valid, 1'b0);
    chk3({tag, "_from"}, from, 3'd0);
    chk3({tag, "_to"}, to, 3'd0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk3({tag, "_epos"}, empty_pos, 3'd0);
    chk8({tag, "_left"}, moves_left, 8'd0);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #3 reset_n = 1'b1;
    tick();
  endtask

  task automatic do_start(input logic [7:0] n, input logic [2:0] e);
    start      = 1'b1;
    nmoves     = n;
    empty_init = e;
    tick();
    start      = 1'b0;
  endtask

  function automatic bit adjacent(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] d;
    d = a - b;
    return (d == 3'd1) || (d == 3'd7) || (((a ^ b) == 3'd4) && (a[1:0] == 2'b00));
  endfunction

  function automatic logic [7:0] model_lfsr(input logic [7:0] r);
    return r[0] ? ((r >> 1) ^ 8'hB8) : (r >> 1);
  endfunction

  function automatic logic [2:0] model_pick(input logic [2:0] e, input logic [2:0] p,
                                            input logic pv, input logic [7:0] r);
    logic [2:0] q[$];
    logic [1:0] idx;
    q.push_back(e + 3'd1);
    q.push_back(e - 3'd1);
    if (e == 3'd0 || e == 3'd4) q.push_back(e ^ 3'd4);
    if (pv) begin
      for (int i = 0; i < q.size(); i++) begin
        if (q[i] == p) begin
          q.delete(i);
          break;
        end
      end
    end
    if (q.size() == 1) return q[0];
    if (q.size() == 2) return q[r[0]];
    idx = (r[1:0] == 2'b11) ? {1'b0, r[2]} : r[1:0];
    return q[idx];
  endfunction

  initial begin
    logic [7:0] m_lfsr;
    logic [2:0] m_empty, m_prev, board_e, exp_from;
    logic       m_pv, rdy, fin, abort;
    int         total, nm, got, cyc;

    reset_n = 1'b0; start = 1'b0; nmoves = 8'd0; empty_init = 3'd0; move_ready = 1'b0;
    #22;
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // one move from e=1: candidates (2,0), lfsr[0]=1 -> from 0
    move_ready = 1'b1;
    do_start(8'd1, 3'd1);
    chk1("s1_valid", move_valid, 1'b1);
    chk3("s1_from", from, 3'd0);
    chk3("s1_to", to, 3'd1);
    chk1("s1_busy", busy, 1'b1);
    chk8("s1_left", moves_left, 8'd1);
    tick();
    chk1("s1_done", done, 1'b1);
    chk1("s1_valid_end", move_valid, 1'b0);
    chk1("s1_busy_end", busy, 1'b0);
    chk3("s1_epos", empty_pos, 3'd0);
    chk8("s1_left_end", moves_left, 8'd0);
    tick();
    chk1("s1_done_once", done, 1'b0);

    // two moves: (0->1) then e=0, prev=1, candidates (7,4), lfsr=B8 -> from 7
    do_reset();
    do_start(8'd2, 3'd1);
    chk3("s2_m1_from", from, 3'd0);
    chk3("s2_m1_to", to, 3'd1);
    chk8("s2_m1_left", moves_left, 8'd2);
    tick();
    chk1("s2_m2_valid", move_valid, 1'b1);
    chk3("s2_m2_from", from, 3'd7);
    chk3("s2_m2_to", to, 3'd0);
    chk8("s2_m2_left", moves_left, 8'd1);
    chk1("s2_m2_nodone", done, 1'b0);
    tick();
    chk1("s2_done", done, 1'b1);
    chk3("s2_epos", empty_pos, 3'd7);
    chk8("s2_left_end", moves_left, 8'd0);
    tick();

    // backpressure: first move held for five cycles, nothing advances
    do_reset();
    move_ready = 1'b0;
    do_start(8'd2, 3'd1);
    for (int i = 0; i < 5; i++) begin
      chk1("bp_valid", move_valid, 1'b1);
      chk3("bp_from", from, 3'd0);
      chk3("bp_to", to, 3'd1);
      chk8("bp_left", moves_left, 8'd2);
      tick();
    end
    move_ready = 1'b1;
    tick();
    chk3("bp_m2_from", from, 3'd7);
    chk3("bp_m2_to", to, 3'd0);
    chk8("bp_m2_left", moves_left, 8'd1);
    tick();
    chk1("bp_done", done, 1'b1);
    chk3("bp_epos", empty_pos, 3'd7);
    tick();

    // zero-move request: done next cycle, no move, empty cell untouched
    do_start(8'd0, 3'd3);
    chk1("z_valid", move_valid, 1'b0);
    chk1("z_done", done, 1'b1);
    chk1("z_busy", busy, 1'b0);
    chk3("z_epos", empty_pos, 3'd7);
    tick();
    chk1("z_done_once", done, 1'b0);
    chk1("z_valid2", move_valid, 1'b0);

    // start while busy or done is ignored
    do_reset();
    move_ready = 1'b0;
    do_start(8'd2, 3'd1);
    do_start(8'd5, 3'd3);
    chk8("ign_left", moves_left, 8'd2);
    chk3("ign_from", from, 3'd0);
    chk3("ign_to", to, 3'd1);
    move_ready = 1'b1;
    tick();
    chk3("ign_m2_from", from, 3'd7);
    chk8("ign_m2_left", moves_left, 8'd1);
    tick();
    chk1("ign_done", done, 1'b1);
    chk8("ign_left_end", moves_left, 8'd0);
    do_start(8'd4, 3'd2);
    chk1("ign_done_busy", busy, 1'b0);
    chk1("ign_done_valid", move_valid, 1'b0);
    chk3("ign_done_epos", empty_pos, 3'd7);

    // reset mid-sequence; third move e=7 prev=0 leaves only cell 6
    do_reset();
    do_start(8'd5, 3'd1);
    chk8("mr_left5", moves_left, 8'd5);
    tick();
    chk3("mr_m2_from", from, 3'd7);
    tick();
    chk8("mr_left3", moves_left, 8'd3);
    chk3("mr_m3_from", from, 3'd6);
    chk3("mr_m3_to", to, 3'd7);
    #3 reset_n = 1'b0;
    #1;
    chk_all_zero("mr_async");
    for (int i = 0; i < 2; i++) begin
      tick();
      chk1("mr_no_done", done, 1'b0);
    end
    #2 reset_n = 1'b1;
    tick();
    do_start(8'd1, 3'd1);
    chk3("mr_re_from", from, 3'd0);
    chk3("mr_re_to", to, 3'd1);
    tick();
    chk1("mr_re_done", done, 1'b1);
    chk3("mr_re_epos", empty_pos, 3'd0);
    tick();

    // soak: random scrambles under random backpressure against a board model
    do_reset();
    move_ready = 1'b0;
    m_lfsr = 8'h01; m_prev = 3'd0; board_e = 3'd5; total = 0; abort = 1'b0;
    while (total < 1000 && !abort) begin
      nm = int'($urandom_range(1, 16));
      do_start(8'(nm), board_e);
      m_empty = board_e; m_pv = 1'b0; got = 0; cyc = 0; fin = 1'b0;
      while (!fin) begin
        if (done) begin
          chk8("soak_count", 8'(got), 8'(nm));
          chk1("soak_valid_end", move_valid, 1'b0);
          fin = 1'b1;
        end else if (cyc > 100) begin
          chk1("soak_timeout", done, 1'b1);
          abort = 1'b1;
          fin = 1'b1;
        end else begin
          chk1("soak_valid", move_valid, 1'b1);
          exp_from = model_pick(m_empty, m_prev, m_pv, m_lfsr);
          chk3("soak_from", from, exp_from);
          chk3("soak_to", to, m_empty);
          chk3("soak_epos", empty_pos, m_empty);
          chk1("soak_adj", adjacent(from, to), 1'b1);
          chk1("soak_undo", m_pv && (from == m_prev), 1'b0);
          rdy = 1'($urandom_range(0, 1));
          move_ready = rdy;
          if (move_valid && rdy) begin
            m_prev  = m_empty;
            m_pv    = 1'b1;
            m_empty = exp_from;
            m_lfsr  = model_lfsr(m_lfsr);
            got++;
            total++;
          end
          tick();
          cyc++;
        end
      end
      move_ready = 1'b0;
      board_e = m_empty;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
